// File: rtl/code_epoch_counter.sv
// Chip-rate code-phase counter: counts chip strobes modulo the C/A code length,
// emits 1 ms and nav-bit epoch pulses, and swallows strobes on slew commands.
module code_epoch_counter #(
    parameter int CHIP_WIDTH = 10,
    parameter int CODE_LEN   = 1023,
    parameter int BIT_MS     = 20,
    parameter int MS_WIDTH   = 5
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  chip_en,
    input  logic                  slew_valid,
    input  logic [CHIP_WIDTH-1:0] slew_chips,
    output logic                  slew_ready,
    input  logic                  bit_sync,
    output logic [CHIP_WIDTH-1:0] chip_cnt,
    output logic [MS_WIDTH-1:0]   ms_cnt,
    output logic                  epoch_1ms,
    output logic                  epoch_bit,
    output logic                  busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SLEW = 1'b1
    } state_t;

    state_t                state_r;
    logic [CHIP_WIDTH-1:0] chip_r;
    logic [MS_WIDTH-1:0]   ms_r;
    logic [CHIP_WIDTH-1:0] remaining_r;
    logic                  epoch_1ms_r;
    logic                  epoch_bit_r;
    logic                  busy_r;
    logic                  ready_r;

    logic                  code_wrap_s;
    logic                  bit_wrap_s;
    logic                  last_swallow_s;

    // Wrap and slew-exit detection against explicit terminal counts.
    always_comb begin
        code_wrap_s    = (chip_r == CHIP_WIDTH'(CODE_LEN - 1));
        bit_wrap_s     = (ms_r == MS_WIDTH'(BIT_MS - 1));
        last_swallow_s = (remaining_r == CHIP_WIDTH'(1));
    end

    // Main FSM with counters and registered status/epoch outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            chip_r      <= '0;
            ms_r        <= '0;
            remaining_r <= '0;
            epoch_1ms_r <= 1'b0;
            epoch_bit_r <= 1'b0;
            busy_r      <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            epoch_1ms_r <= 1'b0;
            epoch_bit_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // The strobe in the accept cycle still counts.
                    if (chip_en) begin
                        if (code_wrap_s) begin
                            chip_r      <= '0;
                            epoch_1ms_r <= 1'b1;
                            if (bit_wrap_s) begin
                                ms_r        <= '0;
                                epoch_bit_r <= 1'b1;
                            end else begin
                                ms_r <= ms_r + MS_WIDTH'(1);
                            end
                        end else begin
                            chip_r <= chip_r + CHIP_WIDTH'(1);
                        end
                    end
                    if (slew_valid && (slew_chips != '0)) begin
                        remaining_r <= slew_chips;
                        state_r     <= SLEW;
                        busy_r      <= 1'b1;
                        ready_r     <= 1'b0;
                    end
                end
                SLEW: begin
                    if (chip_en) begin
                        remaining_r <= remaining_r - CHIP_WIDTH'(1);
                        if (last_swallow_s) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            ready_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    remaining_r <= '0;
                    busy_r      <= 1'b0;
                    ready_r     <= 1'b1;
                end
            endcase
            // Bit realignment overrides any ms advance or bit wrap this edge.
            if (bit_sync) begin
                ms_r        <= '0;
                epoch_bit_r <= 1'b0;
            end
        end
    end

    assign chip_cnt   = chip_r;
    assign ms_cnt     = ms_r;
    assign epoch_1ms  = epoch_1ms_r;
    assign epoch_bit  = epoch_bit_r;
    assign busy       = busy_r;
    assign slew_ready = ready_r;

endmodule
